// File: rtl/fp_norm_round_pack.sv
// Result stage of the binary32 add/sub path: iterative normalise, round-to-nearest-even,
// range check and pack, with a valid/ready handshake on both sides.
module fp_norm_round_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [27:0] in_mant,
    input  logic        in_special,
    input  logic [31:0] in_special_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic [2:0]  out_flags
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t             state_reg;
    logic               sign_reg;
    logic signed [10:0] exp_reg;
    logic [27:0]        mant_reg;
    logic [31:0]        out_reg;
    logic [2:0]         flags_reg;

    logic               round_up;
    logic               inexact;
    logic               frac_carry;
    logic [22:0]        rnd_frac;
    logic signed [10:0] rnd_exp;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out       = out_reg;
    assign out_flags = flags_reg;

    // Hidden bit is always 1 in ROUND, so a carry out of the fraction means the
    // significand reached 2.0: bump the exponent and the fraction wraps to zero.
    always_comb begin
        inexact  = |mant_reg[2:0];
        round_up = mant_reg[2] & (mant_reg[1] | mant_reg[0] | mant_reg[3]);
        {frac_carry, rnd_frac} = {1'b0, mant_reg[25:3]} + {23'b0, round_up};
        rnd_exp  = frac_carry ? exp_reg + 11'sd1 : exp_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sign_reg  <= 1'b0;
            exp_reg   <= '0;
            mant_reg  <= '0;
            out_reg   <= '0;
            flags_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        if (in_special) begin
                            out_reg   <= in_special_val;
                            flags_reg <= 3'b000;
                            state_reg <= DONE;
                        end else if (in_mant == 28'd0) begin
                            out_reg   <= {in_sign, 31'b0};
                            flags_reg <= 3'b000;
                            state_reg <= DONE;
                        end else begin
                            sign_reg  <= in_sign;
                            exp_reg   <= {in_exp[9], in_exp};
                            mant_reg  <= in_mant;
                            state_reg <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mant_reg[27]) begin
                        // Right shift folds the dropped bit into sticky.
                        mant_reg <= {1'b0, mant_reg[27:2], mant_reg[1] | mant_reg[0]};
                        exp_reg  <= exp_reg + 11'sd1;
                    end else if (!mant_reg[26]) begin
                        mant_reg <= {mant_reg[26:0], 1'b0};
                        exp_reg  <= exp_reg - 11'sd1;
                    end else begin
                        state_reg <= ROUND;
                    end
                end
                ROUND: begin
                    if (rnd_exp >= 11'sd255) begin
                        out_reg   <= {sign_reg, 8'hFF, 23'b0};
                        flags_reg <= 3'b101;
                    end else if (rnd_exp <= 11'sd0) begin
                        out_reg   <= {sign_reg, 31'b0};
                        flags_reg <= 3'b011;
                    end else begin
                        out_reg   <= {sign_reg, rnd_exp[7:0], rnd_frac};
                        flags_reg <= {2'b00, inexact};
                    end
                    state_reg <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_norm_round_pack.sv
// Bench for fp_norm_round_pack: directed vectors, randomized ops against a value-level model,
// backpressure, back-to-back specials and reset during normalisation.
module tb_fp_norm_round_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [27:0] in_mant;
    logic        in_special;
    logic [31:0] in_special_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [2:0]  out_flags;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_norm_round_pack dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_special(in_special), .in_special_val(in_special_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_flags(out_flags)
    );

    // Value-level model: normalise by leading-one position, round on the 3 dropped bits.
    function automatic void ref_model(input logic s, input logic [9:0] e_in, input logic [27:0] m_in,
                                      output logic [31:0] o, output logic [2:0] f, output int lat);
        int          e;
        int          n;
        int          msb;
        int          grs;
        logic [27:0] m;
        logic [24:0] q;
        if (m_in == 28'd0) begin
            o = {s, 31'b0};
            f = 3'b000;
            lat = 1;
            return;
        end
        e = $signed(e_in);
        if (m_in[27]) begin
            m = (m_in >> 1) | {27'b0, m_in[0]};
            e = e + 1;
            n = 1;
        end else begin
            msb = 0;
            for (int i = 0; i < 27; i++) if (m_in[i]) msb = i;
            n = 26 - msb;
            m = m_in << n;
            e = e - n;
        end
        q   = {1'b0, m[26:3]};
        grs = int'(m[2:0]);
        if (grs > 4 || (grs == 4 && q[0])) q = q + 25'd1;
        if (q[24]) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            o = {s, 8'hFF, 23'b0};
            f = 3'b101;
        end else if (e <= 0) begin
            o = {s, 31'b0};
            f = 3'b011;
        end else begin
            o = {s, e[7:0], q[22:0]};
            f = {2'b00, grs != 0};
        end
        lat = 3 + n;
    endfunction

    // Presents one word in IDLE, then waits (bounded) for out_valid; leaves the DUT in DONE.
    task automatic run_op(input logic s, input logic [9:0] e, input logic [27:0] m,
                          input logic sp, input logic [31:0] sv,
                          output logic [31:0] o, output logic [2:0] f, output int lat);
        @(negedge clk);
        in_sign = s; in_exp = e; in_mant = m; in_special = sp; in_special_val = sv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_mant = 28'($urandom); in_exp = 10'($urandom); in_special_val = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        o = out;
        f = out_flags;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (out !== 32'h0 || out_flags !== 3'b000 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: out=%h flags=%b valid=%b required out=0 flags=000 valid=0", out, out_flags, out_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic        vs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [9:0]  ve[7]  = '{10'd128, 10'd128, 10'd0, 10'd5, 10'd127, 10'd254, 10'd3};
        logic [27:0] vm[7]  = '{28'h7666668, 28'hECCCCD0, 28'h0, 28'h0, 28'h4000004, 28'h7FFFFFC, 28'h0000008};
        logic        vsp[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] vo[7]  = '{32'h406CCCCD, 32'h40ECCCCD, 32'h7FC00000, 32'h80000000,
                                32'h3F800000, 32'h7F800000, 32'h80000000};
        logic [2:0]  vf[7]  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b101, 3'b011};
        int          vl[7]  = '{3, 4, 1, 1, 3, 3, 26};
        logic [31:0] o;
        logic [2:0]  f;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            run_op(vs[i], ve[i], vm[i], vsp[i], 32'h7FC00000, o, f, lat);
            n_cmp++;
            if (o !== vo[i] || f !== vf[i] || lat != vl[i]) begin
                n_bad++;
                $display("FAIL directed[%0d]: out=%h flags=%b lat=%0d required out=%h flags=%b lat=%0d",
                         i, o, f, lat, vo[i], vf[i], vl[i]);
            end
            $display("directed[%0d] out=%h flags=%b lat=%0d", i, o, f, lat);
            consume();
        end
    endtask

    task automatic test_random();
        logic        s;
        logic [9:0]  e;
        logic [27:0] m;
        logic        sp;
        logic [31:0] sv;
        logic [31:0] o;
        logic [2:0]  f;
        int          lat;
        logic [31:0] eo;
        logic [2:0]  ef;
        int          el;
        for (int i = 0; i < 40; i++) begin
            s  = 1'($urandom);
            e  = 10'($urandom_range(0, 400)) - 10'd100;
            m  = 28'($urandom) >> $urandom_range(0, 27);
            sp = ($urandom_range(0, 7) == 0);
            sv = $urandom;
            if (sp) begin
                eo = sv; ef = 3'b000; el = 1;
            end else begin
                ref_model(s, e, m, eo, ef, el);
            end
            run_op(s, e, m, sp, sv, o, f, lat);
            n_cmp++;
            if (o !== eo || f !== ef || lat != el) begin
                n_bad++;
                $display("FAIL random[%0d]: out=%h flags=%b lat=%0d required out=%h flags=%b lat=%0d",
                         i, o, f, lat, eo, ef, el);
            end
            $display("random[%0d] s=%b e=%0d m=%h sp=%b out=%h flags=%b lat=%0d", i, s, $signed(e), m, sp, o, f, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] o;
        logic [2:0]  f;
        int          lat;
        run_op(1'b0, 10'd128, 28'h7666668, 1'b0, 32'h0, o, f, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_special = 1'b1; in_special_val = $urandom;
            @(negedge clk);
            n_cmp++;
            if (out !== 32'h406CCCCD || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL backpressure[%0d]: out=%h valid=%b in_ready=%b required 406ccccd/1/0",
                         i, out, out_valid, in_ready);
            end
        end
        in_valid = 1'b0; in_special = 1'b0;
        consume();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        $display("backpressure held out=%h", out);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            in_valid = 1'b1; in_special = 1'b1; in_special_val = v;
            @(negedge clk);
            in_special_val = ~v;
            n_cmp++;
            if (out_valid !== 1'b1 || out !== v || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_done[%0d]: valid=%b out=%h in_ready=%b required 1/%h/0", i, out_valid, out, in_ready, v);
            end
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== v) begin
                n_bad++;
                $display("FAIL b2b_idle[%0d]: valid=%b in_ready=%b out=%h required 0/1/%h", i, out_valid, in_ready, out, v);
            end
            $display("b2b[%0d] out=%h", i, v);
        end
        in_valid = 1'b0; in_special = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic [31:0] o;
        logic [2:0]  f;
        int          lat;
        @(negedge clk);
        in_sign = 1'b1; in_exp = 10'd3; in_mant = 28'h0000008; in_special = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out !== 32'h0 || out_flags !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_midop: valid=%b out=%h flags=%b required 0/0/000", out_valid, out, out_flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_midop_release: in_ready=%b valid=%b required 1/0", in_ready, out_valid);
        end
        run_op(1'b0, 10'd128, 28'h7666668, 1'b0, 32'h0, o, f, lat);
        n_cmp++;
        if (o !== 32'h406CCCCD || f !== 3'b000 || lat != 3) begin
            n_bad++;
            $display("FAIL reset_midop_after: out=%h flags=%b lat=%0d required 406ccccd/000/3", o, f, lat);
        end
        $display("after reset out=%h flags=%b lat=%0d", o, f, lat);
        consume();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
        in_special = 1'b0; in_special_val = '0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_norm_round_pack.md
# fp_norm_round_pack

Result-side stage of the single-precision (IEEE-754 binary32) add/subtract datapath. Operand-side special-case detection classifies inputs and supplies a bypass value for special cases. This block is the output end of the same path:
- accepts the unpacked sum (or the special-case bypass word) over a valid/ready handshake;
- normalises iteratively, one shift per clock;
- rounds to nearest-even;
- detects exponent overflow/underflow;
- packs and holds the 32-bit result until it is consumed.

## Interface
Parameters: none (binary32 fixed).
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  block can accept; high only in IDLE
- in_sign  in  1  result sign
- in_exp  in  10  two's-complement biased exponent of the bit-26 position of in_mant
- in_mant  in  28  [27]=carry, [26]=hidden, [25:3]=fraction, [2]=G, [1]=R, [0]=S
- in_special  in  1  1 = bypass: output in_special_val unchanged
- in_special_val  in  32  packed special result (Inf/NaN/zero)
- out_valid  out  1  result held in out
- out_ready  in  1  consumer accepts result
- out  out  32  packed binary32 result, registered
- out_flags  out  3  {overflow, underflow, inexact}, registered

## Operation
- Internal exponent register: 11-bit signed, sign-extended from in_exp. It never wraps.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE: in_ready=1. Acceptance occurs when in_valid&&in_ready at a clock edge.
  - in_special=1: out<=in_special_val, flags<=0, go to DONE.
  - Else in_mant==0: out<={in_sign,31'b0}, flags<=0, go to DONE.
  - Else load sign/exp/mant, go to NORM.
- NORM: one action per cycle, in priority order:
  - mant[27]=1: mant<=mant>>1 with new bit0 = old bit1|old bit0 (sticky kept); exp+1.
  - Else mant[26]=0: mant<=mant<<1, zero fill; exp-1.
  - Else go to ROUND.
- ROUND:
  - inexact = G|R|S.
  - Increment mant[26:3] when G&(R|S|mant[3]).
  - Increment carry into bit 27: exp+1, fraction=0.
  - Range check on the final exponent:
    - exp>=255: out={sign,8'hFF,23'b0}, flags=3'b101.
    - exp<=0: out={sign,31'b0}, flags=3'b011 (flush to zero; no denormal output).
    - Else: out={sign,exp[7:0],mant[25:3]}, flags={2'b00,inexact}.
  - Go to DONE.
- DONE: out_valid=1; out/out_flags held stable. Go to IDLE on out_ready=1.
- in_valid/in_* are ignored outside IDLE. Inputs are sampled only at acceptance.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, out=32'h0, out_flags=3'b000, out_valid=0.
  - in_ready=1 in the first cycle after rst_n deasserts.
- Reset mid-operation: any in-flight word is discarded and no output is produced.
- in_ready and out_valid are decoded from the state register, with no combinational path from inputs.
- Latency, acceptance edge to out_valid high:
  - special or zero input: 1 cycle;
  - otherwise: 3 + n cycles, where n = number of NORM shifts (0..26).
- Handshake:
  - out_ready may be held low indefinitely; out is stable throughout.
  - DONE→IDLE on the edge where out_ready=1, then the next acceptance is possible one edge later.
  - Minimum spacing is 2 cycles per operation.

## Test plan
- Normalised 3.7: sign 0, exp 128, mant {2'b01,23'h6CCCCD,3'b000} -> out 0x406CCCCD, flags 000, out_valid 3 cycles after acceptance.
- Carry (3.7+3.7): exp 128, mant 28'hECCCCD0 -> one right shift -> out 0x40ECCCCD (7.4), flags 000, latency 4.
- Bypass: in_special=1, val 0x7FC00000 -> out 0x7FC00000, flags 000, latency 1. Zero: mant 0, sign 1 -> 0x80000000, latency 1.
- Rounding:
  - exp 127, mant {01,23'h0,3'b100} (tie, even LSB) -> 0x3F800000, flags 001.
  - exp 254, mant {01,23'h7FFFFF,3'b100} -> round carries exp to 255 -> 0x7F800000, flags 101.
- Deep normalise and underflow: sign 1, exp 3, mant 28'h0000008 -> 23 left shifts, exp -20 -> 0x80000000, flags 011, latency 26.
- Backpressure and reset:
  - out_ready low 5 cycles in DONE -> out stable, in_ready 0.
  - rst_n pulsed low during NORM -> out_valid 0 and out 0 immediately; in_ready 1 after release; a fresh 3.7 input then completes normally.
